// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: adds two NIBBLES*4-bit operands one nibble per clock,
// LSB nibble first, through a single 4-bit ripple slice fed from a carry register.
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout,
   output logic                   busy
);

   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [NIBBLES-1:0][3:0] a_q, b_q, sum_q;
   logic [IW-1:0]           idx;
   logic                    carry;
   logic                    cout_q;

   logic [3:0] a_nib, b_nib, s_nib;
   logic [4:0] c_chain;
   logic       c_nib;

   // One full_3 cell: returns {carry_out, sum_bit}.
   function automatic logic [1:0] full_3(input logic x, input logic y, input logic ci);
      return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
   endfunction

   // Select the current operand nibbles and ripple them through four full_3 cells.
   always_comb begin
      a_nib   = '0;
      b_nib   = '0;
      s_nib   = '0;
      c_chain = '0;
      for (int n = 0; n < NIBBLES; n++) begin
         if (idx == IW'(n)) begin
            a_nib = a_q[n];
            b_nib = b_q[n];
         end
      end
      c_chain[0] = carry;
      for (int k = 0; k < 4; k++) begin
         {c_chain[k+1], s_nib[k]} = full_3(a_nib[k], b_nib[k], c_chain[k]);
      end
      c_nib = c_chain[4];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (idx == LAST) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture on acceptance; operands need no reset since RUN always follows a load.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         a_q <= a;
         b_q <= b;
      end
   end

   // Carry, nibble index and result registers; index stops at the last nibble.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx    <= '0;
         carry  <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  carry <= cin;
                  idx   <= '0;
               end
            end
            RUN: begin
               carry <= c_nib;
               for (int n = 0; n < NIBBLES; n++) begin
                  if (idx == IW'(n)) sum_q[n] <= s_nib;
               end
               if (idx == LAST) cout_q <= c_nib;
               else             idx    <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: NIBBLES=4 and NIBBLES=1 instances, table vectors,
// hand sequences for handshake corners, and random operands against a plain-arithmetic model.
module tb_nibble_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
   logic [15:0] a, b, sum;

   logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
   logic [3:0]  a1, b1, sum1;

   int passed = 0;
   int total  = 0;

   nibble_serial_adder #(.NIBBLES(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   nibble_serial_adder #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .busy(busy1)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] s;
      logic        co;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
      return 17'(x) + 17'(y) + 17'(c);
   endfunction

   // One operation on the 4-nibble instance; starts and ends on a falling edge.
   task automatic op4(input logic [15:0] x, input logic [15:0] y, input logic c,
                      input logic [15:0] es, input logic ec, input string tag);
      int lat;
      lat = 0;
      while (!in_ready && lat < 20) begin @(negedge clk); lat++; end
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; a = x; b = y; cin = c; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
      chk({tag, " latency"}, 32'(lat), 32'd4);
      chk({tag, " sum"}, 32'(sum), 32'(es));
      chk({tag, " cout"}, 32'(cout), 32'(ec));
      @(negedge clk);
      chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
      chk({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, " sum held"}, 32'(sum), 32'(es));
   endtask

   // One operation on the 1-nibble instance.
   task automatic op1(input logic [3:0] x, input logic [3:0] y, input logic c,
                      input logic [3:0] es, input logic ec, input string tag);
      int lat;
      in_valid1 = 1'b1; a1 = x; b1 = y; cin1 = c; out_ready1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom);
      lat = 0;
      while (!out_valid1 && lat < 20) begin @(negedge clk); lat++; end
      chk({tag, " latency"}, 32'(lat), 32'd1);
      chk({tag, " sum"}, 32'(sum1), 32'(es));
      chk({tag, " cout"}, 32'(cout1), 32'(ec));
      @(negedge clk);
      chk({tag, " out_valid drop"}, 32'(out_valid1), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[5];
      logic [15:0] x, y;
      logic        c;
      logic [16:0] e;
      logic [15:0] pa[3], pb[3];
      int          vcyc[$];
      logic [16:0] res[$];
      int          k, cyc;

      tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
      tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      tbl[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};

      rst = 1'b1;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
      in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset sum", 32'(sum), 32'd0);
      chk("reset cout", 32'(cout), 32'd0);
      chk("reset n1 in_ready", 32'(in_ready1), 32'd1);
      chk("reset n1 busy", 32'(busy1), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++)
         op4(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, $sformatf("vec%0d", i));

      for (int i = 0; i < 20; i++) begin
         x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
         e = ref_add(x, y, c);
         op4(x, y, c, e[15:0], e[16], $sformatf("rand%0d", i));
      end

      // Backpressure: result held while out_ready is low; a stray in_valid is ignored.
      in_valid = 1'b1; a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 20) begin @(negedge clk); k++; end
      chk("bp latency", 32'(k), 32'd4);
      for (int i = 0; i < 6; i++) begin
         chk("bp out_valid", 32'(out_valid), 32'd1);
         chk("bp sum", 32'(sum), 32'h1000);
         chk("bp cout", 32'(cout), 32'd0);
         chk("bp in_ready", 32'(in_ready), 32'd0);
         if (i == 2) begin in_valid = 1'b1; a = 16'h1111; b = 16'h1111; end
         if (i == 3) in_valid = 1'b0;
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp release out_valid", 32'(out_valid), 32'd0);
      chk("bp release in_ready", 32'(in_ready), 32'd1);
      chk("bp release busy", 32'(busy), 32'd0);
      chk("bp release sum", 32'(sum), 32'h1000);

      // Reset after two RUN edges abandons the operation.
      in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst busy before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst in_ready", 32'(in_ready), 32'd1);
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst sum", 32'(sum), 32'd0);
      chk("midrst cout", 32'(cout), 32'd0);
      op4(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "after rst");

      // Back-to-back with in_valid and out_ready held high.
      pa[0] = 16'h1111; pb[0] = 16'h2222;
      pa[1] = 16'hABCD; pb[1] = 16'h6543;
      pa[2] = 16'hFFF0; pb[2] = 16'h0010;
      out_ready = 1'b1; in_valid = 1'b1; a = pa[0]; b = pb[0]; cin = 1'b0;
      k = 1; cyc = 0;
      while (res.size() < 3 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (out_valid) begin vcyc.push_back(cyc); res.push_back({cout, sum}); end
         if (in_ready) begin
            if (k < 3) begin a = pa[k]; b = pb[k]; k++; end
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      chk("b2b result count", 32'(res.size()), 32'd3);
      for (int i = 0; i < res.size() && i < 3; i++) begin
         chk($sformatf("b2b result%0d", i), 32'(res[i]), 32'(ref_add(pa[i], pb[i], 1'b0)));
         if (i > 0) chk($sformatf("b2b spacing%0d", i), 32'(vcyc[i] - vcyc[i-1]), 32'd6);
      end
      @(negedge clk);

      op1(4'hF, 4'h1, 1'b1, 4'h1, 1'b1, "n1 vec");
      for (int i = 0; i < 8; i++) begin
         x = 16'($urandom_range(0, 15)); y = 16'($urandom_range(0, 15)); c = 1'($urandom);
         e = 17'(x) + 17'(y) + 17'(c);
         op1(x[3:0], y[3:0], c, e[3:0], e[4], $sformatf("n1 rand%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
